// File: rtl/uart_matrix_loader_pkg.sv
// Shared types and helpers for the UART matrix loader.
// The top-level build option UART_LOADER_TIMEOUT_EN lives in uart_matrix_loader.sv.
package matrix_loader_pkg;

  // Frame fill sequence: matrix A, then matrix B, then hand-off to the multiplier.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Default geometry: 4x4 matrices of bytes, 64k-cycle inter-byte gap limit.
  localparam int DEFAULT_DIM            = 4;
  localparam int DEFAULT_ELEM_W         = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

  // Bytes per element.
  function automatic int bpe_of(input int elem_w);
    return elem_w / 8;
  endfunction

  // Elements per matrix.
  function automatic int n_elem_of(input int dim);
    return dim * dim;
  endfunction

  // Flat bit offset of element idx; element 0 sits at the MSBs (row-major).
  function automatic int elem_lsb(input int idx, input int n_elem, input int elem_w);
    return (n_elem - 1 - idx) * elem_w;
  endfunction

endpackage

// File: rtl/uart_matrix_loader_packer.sv
// byte_elem_packer: assembles ELEM_W-bit elements from an MSB-first byte stream.
// o_elem/o_elem_valid are combinational from the completing byte, so the parent
// can store the element on the same edge that the last byte is accepted.
module byte_elem_packer
  import matrix_loader_pkg::*;
#(
  parameter int ELEM_W = DEFAULT_ELEM_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  input  logic              i_flush,
  output logic [ELEM_W-1:0] o_elem,
  output logic              o_elem_valid
);

  localparam int BPE   = bpe_of(ELEM_W);
  localparam int IDX_W = (BPE > 1) ? $clog2(BPE) : 1;

  logic [ELEM_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic              last_byte;

  // Earlier bytes move up one byte lane; the incoming byte fills the LSBs.
  assign o_elem    = (shift_q << 8) | ELEM_W'(i_byte);
  assign last_byte = (byte_idx_q == IDX_W'(BPE - 1));

  // Next-state for the assembler: flush wins over an incoming byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    o_elem_valid = 1'b0;
    if (i_flush) begin
      shift_d    = '0;
      byte_idx_d = '0;
    end else if (i_valid) begin
      if (last_byte) begin
        o_elem_valid = 1'b1;
        shift_d      = '0;
        byte_idx_d   = '0;
      end else begin
        shift_d    = o_elem;
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  // Assembler state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_reset) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: packs a UART byte stream into matrices A and B, double-buffers
// them and hands complete frames to the systolic multiplier with a one-cycle o_start.
// Build option: define UART_LOADER_TIMEOUT_EN to discard partial frames after
// TIMEOUT_CYCLES idle cycles (o_frame_err pulses); otherwise o_frame_err is 0.
module uart_matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int DIM            = DEFAULT_DIM,
  parameter int ELEM_W         = DEFAULT_ELEM_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic [7:0]                         i_data,
  input  logic                               i_data_valid,
  input  logic                               i_clear,
  input  logic                               i_mul_busy,
  output logic [DIM*DIM*ELEM_W-1:0]          o_mat_a,
  output logic [DIM*DIM*ELEM_W-1:0]          o_mat_b,
  output logic                               o_start,
  output logic [$clog2(2*DIM*DIM+1)-1:0]     o_level,
  output logic                               o_overrun,
  output logic                               o_frame_err
);

  localparam int N_ELEM = n_elem_of(DIM);
  localparam int MAT_W  = N_ELEM * ELEM_W;
  localparam int LVL_W  = $clog2(2 * N_ELEM + 1);
  localparam int EI_W   = $clog2(N_ELEM);

  // Elaboration-time parameter sanity checks.
  if (DIM < 2) begin : g_bad_dim
    $error("uart_matrix_loader: DIM must be at least 2");
  end
  if ((ELEM_W % 8) != 0 || ELEM_W < 8 || ELEM_W > 32) begin : g_bad_elem_w
    $error("uart_matrix_loader: ELEM_W must be a multiple of 8 in 8..32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_matrix_loader: TIMEOUT_CYCLES must be at least 2");
  end

  state_e            state_q, state_d;
  logic [EI_W-1:0]   elem_idx_q, elem_idx_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [MAT_W-1:0]  work_a_q, work_a_d;
  logic [MAT_W-1:0]  work_b_q, work_b_d;
  logic [MAT_W-1:0]  mat_a_q, mat_a_d;
  logic [MAT_W-1:0]  mat_b_q, mat_b_d;
  logic              start_q, start_d;
  logic              overrun_q, overrun_d;

  logic              timeout;
  logic              flush;
  logic              byte_accept;
  logic [ELEM_W-1:0] elem;
  logic              elem_valid;
  logic              last_elem;

  // Bytes are only taken while filling; anything arriving in COMMIT is dropped.
  assign byte_accept = i_data_valid && (state_q != COMMIT);
  assign flush       = i_clear || timeout;
  assign last_elem   = (elem_idx_q == EI_W'(N_ELEM - 1));

  byte_elem_packer #(
    .ELEM_W (ELEM_W)
  ) u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_byte       (i_data),
    .i_valid      (byte_accept),
    .i_flush      (flush),
    .o_elem       (elem),
    .o_elem_valid (elem_valid)
  );

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             frame_open_q, frame_open_d;
  logic             frame_err_q;
  logic             gap_run;

  // The gap counter only runs while a partially received frame is open.
  assign gap_run = (state_q != COMMIT) && frame_open_q;

  // Gap counter: restarts on every byte strobe and fires once on reaching the limit.
  always_comb begin
    gap_d        = gap_q;
    timeout      = 1'b0;
    frame_open_d = frame_open_q;
    if (i_clear || i_data_valid || !gap_run) begin
      gap_d = '0;
    end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
      gap_d   = '0;
      timeout = 1'b1;
    end else begin
      gap_d = gap_q + 1'b1;
    end
    if (i_clear || timeout || state_q == COMMIT) begin
      frame_open_d = 1'b0;
    end else if (byte_accept) begin
      frame_open_d = 1'b1;
    end
  end

  // Gap counter registers and the registered frame-error pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gap_q        <= '0;
      frame_open_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      gap_q        <= gap_d;
      frame_open_q <= frame_open_d;
      frame_err_q  <= timeout;
    end
  end

  assign o_frame_err = frame_err_q;
`else
  assign timeout     = 1'b0;
  assign o_frame_err = 1'b0;
`endif

  // Frame FSM next-state: fill A, fill B, then commit when the multiplier is free.
  always_comb begin
    state_d    = state_q;
    elem_idx_d = elem_idx_q;
    level_d    = level_q;
    work_a_d   = work_a_q;
    work_b_d   = work_b_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    start_d    = 1'b0;
    overrun_d  = overrun_q;
    if (flush) begin
      // Abort the frame in progress; committed matrices are kept.
      state_d    = LOAD_A;
      elem_idx_d = '0;
      level_d    = '0;
      if (i_clear) begin
        overrun_d = 1'b0;
      end
    end else begin
      case (state_q)
        LOAD_A: begin
          if (elem_valid) begin
            work_a_d[elem_lsb(int'(elem_idx_q), N_ELEM, ELEM_W) +: ELEM_W] = elem;
            level_d = level_q + 1'b1;
            if (last_elem) begin
              elem_idx_d = '0;
              state_d    = LOAD_B;
            end else begin
              elem_idx_d = elem_idx_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (elem_valid) begin
            work_b_d[elem_lsb(int'(elem_idx_q), N_ELEM, ELEM_W) +: ELEM_W] = elem;
            level_d = level_q + 1'b1;
            if (last_elem) begin
              elem_idx_d = '0;
              state_d    = COMMIT;
            end else begin
              elem_idx_d = elem_idx_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (!i_mul_busy) begin
            mat_a_d = work_a_q;
            mat_b_d = work_b_q;
            start_d = 1'b1;
            level_d = '0;
            state_d = LOAD_A;
          end else if (i_data_valid) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d    = LOAD_A;
          elem_idx_d = '0;
          level_d    = '0;
        end
      endcase
    end
  end

  // FSM, buffers and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the wide working and committed buffers are reset too, so o_mat_a/o_mat_b
      // read as zero after reset rather than as stale data.
      state_q    <= LOAD_A;
      elem_idx_q <= '0;
      level_q    <= '0;
      work_a_q   <= '0;
      work_b_q   <= '0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      start_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      level_q    <= level_d;
      work_a_q   <= work_a_d;
      work_b_q   <= work_b_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
      start_q    <= start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_mat_a   = mat_a_q;
  assign o_mat_b   = mat_b_q;
  assign o_start   = start_q;
  assign o_level   = level_q;
  assign o_overrun = overrun_q;

endmodule
